// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
// Optional build macro used by the top: SHIFT_ARB_STATS_EN.
package shift_arb_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 8;
  localparam int STATS_W     = 16;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_core.sv
// Combinational ARM-style barrel shifter: LSL/LSR/ASR/ROR with the full
// shift-amount range and carry-out. Amounts are widened to 32 bits before any
// arithmetic so DATA_W - s never wraps.
module shift_core
  import shift_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         sh,
  output logic [DATA_W-1:0]  y,
  output logic               carry
);

  localparam int          LW = $clog2(DATA_W);
  localparam logic [31:0] DW = 32'(DATA_W);

  logic [31:0]       s;
  logic [LW-1:0]     idx;
  logic [LW-1:0]     r;
  logic [DATA_W-1:0] rot;

  // Shift result and carry for every type and amount range.
  always_comb begin
    s     = 32'(shamt);
    idx   = '0;
    r     = s[LW-1:0];
    rot   = (a >> r) | (a << (DW - 32'(r)));
    y     = a;
    carry = 1'b0;
    if (s != 32'd0) begin
      case (shift_type_e'(sh))
        SH_LSL: begin
          if (s < DW) begin
            y     = a << s;
            idx   = LW'(DW - s);
            carry = a[idx];
          end else if (s == DW) begin
            y     = '0;
            carry = a[0];
          end else begin
            y     = '0;
            carry = 1'b0;
          end
        end
        SH_LSR: begin
          if (s < DW) begin
            y     = a >> s;
            idx   = LW'(s - 32'd1);
            carry = a[idx];
          end else if (s == DW) begin
            y     = '0;
            carry = a[DATA_W-1];
          end else begin
            y     = '0;
            carry = 1'b0;
          end
        end
        SH_ASR: begin
          if (s < DW) begin
            y     = $signed(a) >>> s;
            idx   = LW'(s - 32'd1);
            carry = a[idx];
          end else begin
            y     = {DATA_W{a[DATA_W-1]}};
            carry = a[DATA_W-1];
          end
        end
        default: begin
          // Rotating by a whole multiple of the width leaves a unchanged but
          // still reports the top bit as carry.
          if (r == '0) begin
            y     = a;
            carry = a[DATA_W-1];
          end else begin
            y     = rot;
            carry = rot[DATA_W-1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between two requesters.
// One registered result is held; it can be drained and replaced in the same
// cycle for full throughput.
// Handshake: a transfer happens on a channel in any cycle where valid and
// ready are both 1; req*_ready are combinational and never depend on the
// same requester's operands, rsp_* are registered and held while not taken.
// Optional build macro: SHIFT_ARB_STATS_EN adds per-id response counters.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_sh,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_sh,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_y,
  output logic               rsp_carry,
  output logic               rsp_id,
`ifdef SHIFT_ARB_STATS_EN
  output logic [STATS_W-1:0] stat_cnt0,
  output logic [STATS_W-1:0] stat_cnt1,
`endif
  output state_e             dbg_state
);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   rsp_y_q;
  logic                rsp_carry_q;
  logic                rsp_id_q;

  logic                accept;
  logic                gnt0, gnt1, gnt_any;
  logic                rsp_hs;
  logic [DATA_W-1:0]   sel_a;
  logic [SHAMT_W-1:0]  sel_shamt;
  logic [1:0]          sel_sh;
  logic [DATA_W-1:0]   core_y;
  logic                core_carry;

  // Grant decision: the slot is free or is being drained; on contention the
  // requester that did not win last time goes first. Gated by rst_n so no
  // operation is acknowledged while reset is held.
  always_comb begin
    rsp_hs  = (state_q == FULL) && rsp_ready;
    accept  = rst_n && ((state_q == EMPTY) || rsp_hs);
    gnt0    = accept && req0_valid && (!req1_valid || last_grant_q);
    gnt1    = accept && req1_valid && (!req0_valid || !last_grant_q);
    gnt_any = gnt0 || gnt1;
    last_grant_d = gnt_any ? gnt1 : last_grant_q;
    sel_a     = gnt1 ? req1_a     : req0_a;
    sel_shamt = gnt1 ? req1_shamt : req0_shamt;
    sel_sh    = gnt1 ? req1_sh    : req0_sh;
  end

  shift_core #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W)
  ) u_core (
    .a    (sel_a),
    .shamt(sel_shamt),
    .sh   (sel_sh),
    .y    (core_y),
    .carry(core_carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next state: any grant fills the slot, a drain without a grant empties it.
  always_comb begin
    state_d = state_q;
    if (gnt_any)     state_d = FULL;
    else if (rsp_hs) state_d = EMPTY;
  end

  // FSM-derived outputs.
  always_comb begin
    rsp_valid  = (state_q == FULL);
    req0_ready = gnt0;
    req1_ready = gnt1;
    dbg_state  = state_q;
  end

  // Result, id and round-robin pointer capture on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_y_q      <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
      if (gnt_any) begin
        rsp_y_q     <= core_y;
        rsp_carry_q <= core_carry;
        rsp_id_q    <= gnt1;
      end
    end
  end

  assign rsp_y     = rsp_y_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = rsp_id_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [STATS_W-1:0] cnt0_q, cnt1_q;

  // Saturating count of responses taken, per requester id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (rsp_hs) begin
      if (!rsp_id_q && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
      if ( rsp_id_q && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: reset values, round-robin order,
// a table of shift vectors, backpressure and asynchronous reset while FULL.
module tb_shift_arbiter;
  import shift_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a;
  logic [7:0]  req0_shamt;
  logic [1:0]  req0_sh;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a;
  logic [7:0]  req1_shamt;
  logic [1:0]  req1_sh;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_carry, rsp_id;
  state_e      dbg_state;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1;
`endif

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];   // {id, carry, y}

  shift_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_sh(req0_sh),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_sh(req1_sh),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_carry(rsp_carry), .rsp_id(rsp_id),
`ifdef SHIFT_ARB_STATS_EN
    .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {carry, y}. Shifts are done in 64 bits so the carry falls out as
  // the bit just beyond the result window.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [7:0] s,
                                        input logic [1:0] sh);
    logic [63:0]        t;
    logic signed [63:0] ts;
    logic [4:0]         r;
    case (sh)
      2'b00: begin t = {32'b0, a} << s; return {t[32], t[31:0]}; end
      2'b01: begin t = {a, 32'b0} >> s; return {t[31], t[63:32]}; end
      2'b10: begin ts = {a, 32'b0}; ts = ts >>> s; return {ts[31], ts[63:32]}; end
      default: begin
        if (s == 8'd0) return {1'b0, a};
        r = s[4:0];
        t = {a, a} >> r;
        return {t[31], t[31:0]};
      end
    endcase
  endfunction

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  // Pop before push: the response visible now belongs to an earlier accept.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_rsp", {30'd0, rsp_id, rsp_carry, rsp_y}, {30'd0, e});
        end
      end
      if (req0_ready && req1_ready) check("sb_double_grant", 64'd1, 64'd0);
      if (req0_valid && req0_ready)
        exp_q.push_back({1'b0, model(req0_a, req0_shamt, req0_sh)});
      if (req1_valid && req1_ready)
        exp_q.push_back({1'b1, model(req1_a, req1_shamt, req1_sh)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [7:0] s,
                        input logic [1:0] sh);
    req0_valid = v; req0_a = a; req0_shamt = s; req0_sh = sh;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [7:0] s,
                        input logic [1:0] sh);
    req1_valid = v; req1_a = a; req1_shamt = s; req1_sh = sh;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] a;
    logic [7:0]  s;
    logic [1:0]  sh;
    logic [31:0] y;
    logic        c;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] held_y;
    logic        held_c, held_id;
    logic        exp_g[4];

    vecs[0]  = '{32'h8000_0001, 8'd1,   2'b11, 32'hC000_0000, 1'b1};
    vecs[1]  = '{32'h0000_0003, 8'd0,   2'b00, 32'h0000_0003, 1'b0};
    vecs[2]  = '{32'h0000_0003, 8'd31,  2'b00, 32'h8000_0000, 1'b1};
    vecs[3]  = '{32'h0000_0003, 8'd32,  2'b00, 32'h0000_0000, 1'b1};
    vecs[4]  = '{32'h0000_0003, 8'd33,  2'b00, 32'h0000_0000, 1'b0};
    vecs[5]  = '{32'h8000_0000, 8'd40,  2'b10, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{32'h8000_0000, 8'd32,  2'b01, 32'h0000_0000, 1'b1};
    vecs[7]  = '{32'h0000_00F0, 8'd4,   2'b01, 32'h0000_000F, 1'b0};
    vecs[8]  = '{32'h8000_0000, 8'd4,   2'b10, 32'hF800_0000, 1'b0};
    vecs[9]  = '{32'h1234_5678, 8'd32,  2'b11, 32'h1234_5678, 1'b0};
    vecs[10] = '{32'h0000_0001, 8'd36,  2'b11, 32'h1000_0000, 1'b0};
    vecs[11] = '{32'hFFFF_FFFF, 8'd255, 2'b00, 32'h0000_0000, 1'b0};
    vecs[12] = '{32'h0000_0018, 8'd4,   2'b01, 32'h0000_0001, 1'b1};
    vecs[13] = '{32'h9000_0000, 8'd33,  2'b01, 32'h0000_0000, 1'b0};

    drive0(1'b1, 32'h1, 8'd1, 2'b00);
    drive1(1'b1, 32'h2, 8'd1, 2'b00);
    rsp_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state, with both requests already pending.
    #3;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_y",     64'(rsp_y), 64'd0);
    check("rst_rsp_carry", 64'(rsp_carry), 64'd0);
    check("rst_rsp_id",    64'(rsp_id), 64'd0);
    check("rst_readies",   {62'd0, req1_ready, req0_ready}, 64'd0);
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    do_reset();

    // Round robin with a free-flowing consumer: 0,1,0,1 and no bubbles.
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, $urandom, 8'($urandom_range(0, 40)), 2'($urandom_range(0, 3)));
      drive1(1'b1, $urandom, 8'($urandom_range(0, 40)), 2'($urandom_range(0, 3)));
      @(negedge clk);
      check("rr_grant", {62'd0, req1_ready, req0_ready},
            exp_g[i] ? 64'd2 : 64'd1);
      check("rr_no_bubble", 64'(rsp_valid), (i > 0) ? 64'd1 : 64'd0);
      step();
    end
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    @(negedge clk);
    check("rr_last_rsp_valid", 64'(rsp_valid), 64'd1);
    step();

    // Table of shift vectors through requester 0, one result per op.
    for (int i = 0; i < 14; i++) begin
      drive0(1'b1, vecs[i].a, vecs[i].s, vecs[i].sh);
      @(negedge clk);
      check("vec_ready", 64'(req0_ready), 64'd1);
      step();
      drive0(1'b0, 0, 0, 0);
      @(negedge clk);
      check("vec_valid", 64'(rsp_valid), 64'd1);
      check("vec_result", {31'd0, rsp_id, rsp_carry, rsp_y},
            {31'd0, 1'b0, vecs[i].c, vecs[i].y});
      step();
    end

    // Backpressure: fill, then hold rsp_ready low for three cycles.
    rsp_ready = 1'b1;
    drive0(1'b1, 32'hA5A5_0F0F, 8'd7, 2'b11);
    drive1(1'b1, 32'h0000_FFFF, 8'd3, 2'b00);
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    held_y = rsp_y; held_c = rsp_carry; held_id = rsp_id;
    check("bp_full", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stable", {30'd0, rsp_valid, rsp_id, rsp_carry, rsp_y},
            {30'd0, 1'b1, held_id, held_c, held_y});
      check("bp_no_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_accept", 64'(req0_ready | req1_ready), 64'd1);
    step();
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    @(negedge clk);
    check("bp_refilled", 64'(rsp_valid), 64'd1);
    step();
    @(negedge clk);
    check("bp_empty", 64'(rsp_valid), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while FULL drops the held result immediately.
    step();
    rsp_ready = 1'b0;
    drive1(1'b1, 32'h0000_0010, 8'd2, 2'b01);
    step();
    drive1(1'b0, 0, 0, 0);
    @(negedge clk);
    check("ar_full", 64'(rsp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid_drop", 64'(rsp_valid), 64'd0);
    exp_q.delete();
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;
`ifdef SHIFT_ARB_STATS_EN
    check("ar_stat0", 64'(stat_cnt0), 64'd0);
    check("ar_stat1", 64'(stat_cnt1), 64'd0);
`endif
    drive0(1'b1, 32'h0000_0001, 8'd31, 2'b00);
    drive1(1'b1, 32'h8000_0000, 8'd31, 2'b10);
    @(negedge clk);
    check("ar_first_grant", {62'd0, req1_ready, req0_ready}, 64'd1);
    step();
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    @(negedge clk);
    check("ar_rsp", {31'd0, rsp_id, rsp_carry, rsp_y}, {31'd0, 1'b0, 1'b0, 32'h8000_0000});
    step();
    step();
    check("sb_final_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
